// File: rtl/ppcpu_rst_pkg.sv
// Shared reset-sequencer definitions: FSM state encoding and reset-domain indices.
package ppcpu_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    SEQ     = 2'd1,
    SASSERT = 2'd2,
    DONE    = 2'd3
  } rst_state_e;

  // Release order: bit 0 (interconnect) comes out of reset first, the core last.
  localparam int RST_DOM_BUS    = 0;
  localparam int RST_DOM_MEM    = 1;
  localparam int RST_DOM_PERIPH = 2;
  localparam int RST_DOM_CORE   = 3;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/reset_seq_wdt.sv
// Watchdog counter for the reset sequencer: runs while enabled, clears on kick, flags expiry.
module reset_seq_wdt
  import ppcpu_rst_pkg::*;
#(
  parameter int WDT_CYCLES = 65536
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_kick,
  output logic o_expire
);

  localparam int WW = clog2_min1(WDT_CYCLES);

  logic [WW-1:0] cnt_q;

  assign o_expire = i_run && !i_kick && (cnt_q == WW'(WDT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (!i_run || i_kick || o_expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + WW'(1);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered per-domain reset release with soft-reset servicing.
// Optional watchdog-triggered soft reset when RESET_SEQ_WDT_EN is defined.
module reset_sequencer
  import ppcpu_rst_pkg::*;
#(
  parameter int N_DOMAINS  = 4,
  parameter int STEP_DELAY = 16
`ifdef RESET_SEQ_WDT_EN
  , parameter int WDT_CYCLES = 65536
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_hold,
  input  logic                 i_soft_rst_req,
  input  logic [N_DOMAINS-1:0] i_soft_mask,
  output logic                 o_soft_rst_ack,
  output logic [N_DOMAINS-1:0] o_rst,
  output logic                 o_busy
`ifdef RESET_SEQ_WDT_EN
  , input  logic               i_wdt_kick
  , output logic               o_wdt_fired
`endif
);

  localparam int CW = $clog2(STEP_DELAY + 1);
  localparam int IW = clog2_min1(N_DOMAINS);

  rst_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N_DOMAINS-1:0] mask_q, mask_d;
  logic [N_DOMAINS-1:0] rst_q, rst_d;
  logic                 ack_q, ack_d;
  logic                 soft_q, soft_d;

`ifdef RESET_SEQ_WDT_EN
  logic wdt_expire;
  logic fired_q, fired_d;

  reset_seq_wdt #(
    .WDT_CYCLES(WDT_CYCLES)
  ) u_wdt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (state_q == DONE),
    .i_kick   (i_wdt_kick),
    .o_expire (wdt_expire)
  );

  assign o_wdt_fired = fired_q;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= IW'(RST_DOM_BUS);
      mask_q  <= '1;
      rst_q   <= '1;
      ack_q   <= 1'b0;
      soft_q  <= 1'b0;
`ifdef RESET_SEQ_WDT_EN
      fired_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      rst_q   <= rst_d;
      ack_q   <= ack_d;
      soft_q  <= soft_d;
`ifdef RESET_SEQ_WDT_EN
      fired_q <= fired_d;
`endif
    end
  end

  // HOLD and SEQ share the release step; HOLD is simply the idx = 0 step after power-on.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    rst_d   = rst_q;
    ack_d   = 1'b0;
    soft_d  = soft_q;
`ifdef RESET_SEQ_WDT_EN
    fired_d = fired_q;
`endif
    case (state_q)
      HOLD, SEQ: begin
        if (!i_hold) begin
          if (cnt_q == CW'(STEP_DELAY - 1)) begin
            cnt_d        = '0;
            rst_d[idx_q] = 1'b0;
            if (idx_q == IW'(N_DOMAINS - 1)) begin
              state_d = DONE;
              ack_d   = soft_q;
              soft_d  = 1'b0;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = SEQ;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SASSERT: begin
        rst_d = rst_q | mask_q;
        if (cnt_q == CW'(STEP_DELAY - 1)) begin
          cnt_d   = '0;
          idx_d   = IW'(RST_DOM_BUS);
          state_d = SEQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
`ifdef RESET_SEQ_WDT_EN
        // Watchdog wins over a simultaneous request and never acknowledges.
        if (wdt_expire) begin
          mask_d  = '1;
          rst_d   = '1;
          cnt_d   = '0;
          soft_d  = 1'b0;
          fired_d = 1'b1;
          state_d = SASSERT;
        end else
`endif
        if (i_soft_rst_req) begin
          if (i_soft_mask != '0) begin
            mask_d  = i_soft_mask;
            rst_d   = rst_q | i_soft_mask;
            cnt_d   = '0;
            soft_d  = 1'b1;
            state_d = SASSERT;
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  assign o_rst          = rst_q;
  assign o_busy         = (state_q != DONE);
  assign o_soft_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: phase tables feed an expected-output scoreboard.
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int N    = 4;
  localparam int STEP = 16;

  typedef struct {
    int         cycles;
    logic       hold;
    logic       req;
    logic [N-1:0] mask;
    logic       kick;
    logic [N-1:0] rst;
    logic       busy;
    logic       ack;
    logic       fired;
    string      name;
  } vec_t;

  typedef struct {
    logic [N-1:0] rst;
    logic       busy;
    logic       ack;
    logic       fired;
    string      name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_in;
  logic         hold, req, kick;
  logic [N-1:0] mask;
  logic         ack, busy, fired;
  logic [N-1:0] orst;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle_n  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle_n++;

  reset_sequencer #(
    .N_DOMAINS  (N),
    .STEP_DELAY (STEP)
`ifdef RESET_SEQ_WDT_EN
    , .WDT_CYCLES (100)
`endif
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst_in),
    .i_hold         (hold),
    .i_soft_rst_req (req),
    .i_soft_mask    (mask),
    .o_soft_rst_ack (ack),
    .o_rst          (orst),
    .o_busy         (busy)
`ifdef RESET_SEQ_WDT_EN
    , .i_wdt_kick   (kick)
    , .o_wdt_fired  (fired)
`endif
  );

`ifndef RESET_SEQ_WDT_EN
  assign fired = 1'b0;
`endif

  function automatic void add(int c, logic h, logic r, logic [N-1:0] m, logic k,
                              logic [N-1:0] er, logic eb, logic ea, logic ef, string nm);
    vec_t v;
    v.cycles = c; v.hold = h; v.req = r; v.mask = m; v.kick = k;
    v.rst = er; v.busy = eb; v.ack = ea; v.fired = ef; v.name = nm;
    vecs.push_back(v);
  endfunction

  // Standard power-on release: edges 1..15 all held, then one bit per 16 edges, DONE at edge 64.
  function automatic void addPowerOn(logic r, logic [N-1:0] m, logic ef, string nm);
    add(15, 0, r, m, 0, 4'b1111, 1, 0, ef, {nm, "_1111"});
    add(16, 0, r, m, 0, 4'b1110, 1, 0, ef, {nm, "_1110"});
    add(16, 0, r, m, 0, 4'b1100, 1, 0, ef, {nm, "_1100"});
    add(16, 0, r, m, 0, 4'b1000, 1, 0, ef, {nm, "_1000"});
    add(1,  0, r, m, 0, 4'b0000, 0, 0, ef, {nm, "_done"});
  endfunction

  task automatic checkOutput();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_empty @cycle %0d: no expected entry", cycle_n);
    end else begin
      e = sb.pop_front();
      if (orst !== e.rst || busy !== e.busy || ack !== e.ack || fired !== e.fired) begin
        n_fail++;
        $display("[TB] FAIL %s @cycle %0d: got rst=%b busy=%b ack=%b fired=%b, expected rst=%b busy=%b ack=%b fired=%b",
                 e.name, cycle_n, orst, busy, ack, fired, e.rst, e.busy, e.ack, e.fired);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    for (int i = 0; i < v.cycles; i++) begin
      hold = v.hold; req = v.req; mask = v.mask; kick = v.kick;
      e.rst = v.rst; e.busy = v.busy; e.ack = v.ack; e.fired = v.fired; e.name = v.name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  task automatic runVectors();
    while (vecs.size() > 0) applyStimulus(vecs.pop_front());
  endtask

  task automatic resetDut(input string nm);
    exp_t e;
    rst_in = 1'b1;
    hold = 0; req = 0; mask = '0; kick = 0;
    repeat (5) @(posedge clk);
    #1;
    e.rst = 4'b1111; e.busy = 1; e.ack = 0; e.fired = 0; e.name = nm;
    sb.push_back(e);
    checkOutput();
    rst_in = 1'b0;
  endtask

  initial begin
    exp_t e;
    // Power-on, then a soft reset of the core domain, then a mask-0 request.
    resetDut("reset_state");
    addPowerOn(0, '0, 0, "poweron");
    add(4,  0, 0, '0,      0, 4'b0000, 0, 0, 0, "poweron_idle");
    add(1,  0, 1, 4'b1000, 0, 4'b1000, 1, 0, 0, "soft_assert");
    add(79, 0, 0, '0,      0, 4'b1000, 1, 0, 0, "soft_hold_seq");
    add(1,  0, 0, '0,      0, 4'b0000, 0, 1, 0, "soft_ack");
    add(2,  0, 0, '0,      0, 4'b0000, 0, 0, 0, "soft_after");
    add(1,  0, 1, '0,      0, 4'b0000, 0, 1, 0, "mask0_ack");
    add(2,  0, 0, '0,      0, 4'b0000, 0, 0, 0, "mask0_after");
    runVectors();

    // Hold high for edges 20..29 stretches every later release by 10.
    resetDut("reset_state_hold");
    add(15, 0, 0, '0, 0, 4'b1111, 1, 0, 0, "hold_1111");
    add(4,  0, 0, '0, 0, 4'b1110, 1, 0, 0, "hold_pre");
    add(10, 1, 0, '0, 0, 4'b1110, 1, 0, 0, "hold_frozen");
    add(12, 0, 0, '0, 0, 4'b1110, 1, 0, 0, "hold_post");
    add(16, 0, 0, '0, 0, 4'b1100, 1, 0, 0, "hold_1100");
    add(16, 0, 0, '0, 0, 4'b1000, 1, 0, 0, "hold_1000");
    add(3,  0, 0, '0, 0, 4'b0000, 0, 0, 0, "hold_done");
    runVectors();

    // Request held through power-on is serviced on the first DONE cycle.
    resetDut("reset_state_req");
    addPowerOn(1, 4'b0100, 0, "poweron_req");
    add(1,  0, 1, 4'b0100, 0, 4'b0100, 1, 0, 0, "held_req_assert");
    add(63, 0, 0, '0,      0, 4'b0100, 1, 0, 0, "held_req_hold");
    add(16, 0, 0, '0,      0, 4'b0000, 1, 0, 0, "held_req_tail");
    add(1,  0, 0, '0,      0, 4'b0000, 0, 1, 0, "held_req_ack");
    add(2,  0, 0, '0,      0, 4'b0000, 0, 0, 0, "held_req_after");
    add(1,  0, 1, 4'b1000, 0, 4'b1000, 1, 0, 0, "midrst_assert");
    add(5,  0, 0, '0,      0, 4'b1000, 1, 0, 0, "midrst_sassert");
    runVectors();

    // Asynchronous reset while in SASSERT: outputs snap back before any clock edge.
    @(negedge clk);
    rst_in = 1'b1;
    #1;
    e.rst = 4'b1111; e.busy = 1; e.ack = 0; e.fired = 0; e.name = "async_reset";
    sb.push_back(e);
    checkOutput();
    resetDut("reset_state_restart");
    addPowerOn(0, '0, 0, "restart");
    add(20, 0, 0, '0, 0, 4'b0000, 0, 0, 0, "restart_noack");
    runVectors();

`ifdef RESET_SEQ_WDT_EN
    resetDut("reset_state_wdt");
    addPowerOn(0, '0, 0, "wdt_poweron");
    add(1, 0, 0, '0, 0, 4'b0000, 0, 0, 0, "wdt_idle0");
    for (int j = 0; j < 4; j++) begin
      add(1,  0, 0, '0, 1, 4'b0000, 0, 0, 0, "wdt_kick");
      add(49, 0, 0, '0, 0, 4'b0000, 0, 0, 0, "wdt_kicked_idle");
    end
    add(1,  0, 0, '0, 1, 4'b0000, 0, 0, 0, "wdt_last_kick");
    add(99, 0, 0, '0, 0, 4'b0000, 0, 0, 0, "wdt_countdown");
    add(32, 0, 0, '0, 0, 4'b1111, 1, 0, 1, "wdt_fire");
    add(16, 0, 0, '0, 0, 4'b1110, 1, 0, 1, "wdt_1110");
    add(16, 0, 0, '0, 0, 4'b1100, 1, 0, 1, "wdt_1100");
    add(16, 0, 0, '0, 0, 4'b1000, 1, 0, 1, "wdt_1000");
    add(1,  0, 0, '0, 0, 4'b0000, 0, 0, 1, "wdt_done_noack");
    add(3,  0, 0, '0, 0, 4'b0000, 0, 0, 1, "wdt_sticky");
    runVectors();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL sim_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the 4-stage reset synchronizer.
- Consumes its synchronized reset on i_rst and releases N_DOMAINS per-block resets (e.g. bus/interconnect, memory ctrl, peripherals, CPU core) one at a time, with a fixed gap between releases.
- Also services soft-reset requests from the system controller: it re-asserts a masked subset of domains, then runs the same ordered release.

Parameters:
- N_DOMAINS, 4, number of reset outputs; bit 0 is released first. Range 1..16.
- STEP_DELAY, 16, cycles between consecutive releases and soft-assert hold length. Must be >= 1.
- WDT_CYCLES, 65536, watchdog timeout in cycles. Used only with RESET_SEQ_WDT_EN.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high (synchronized source)
- i_hold  in  1  freezes the release counter while high (e.g. debugger holds core in reset)
- i_soft_rst_req  in  1  level request for soft reset, sampled only in DONE
- i_soft_mask  in  N_DOMAINS  domains to reset; sampled together with the request
- o_soft_rst_ack  out  1  one-cycle pulse when a soft request completes
- o_rst  out  N_DOMAINS  per-domain active-high resets, registered
- o_busy  out  1  high whenever state != DONE
- i_wdt_kick  in  1  present only with RESET_SEQ_WDT_EN
- o_wdt_fired  out  1  present only with RESET_SEQ_WDT_EN

Behaviour:
- Reset values (async on i_rst):
  - state = HOLD, cnt = 0, idx = 0, mask register = all ones.
  - o_rst = all ones, o_busy = 1, o_soft_rst_ack = 0, o_wdt_fired = 0.
- Counter width: $clog2(STEP_DELAY+1). idx width: $clog2(N_DOMAINS), minimum 1.
- HOLD (after i_rst falls):
  - cnt increments each cycle unless i_hold.
  - When cnt == STEP_DELAY-1: clear o_rst[0], set cnt = 0, go to SEQ with idx = 1.
  - If N_DOMAINS == 1, go directly to DONE.
- Release timing: o_rst[k] falls exactly (k+1)*STEP_DELAY rising edges after the first edge with i_rst low, plus any cycles with i_hold high.
- SEQ:
  - Same counting; on expiry clear o_rst[idx] and increment idx.
  - When the last index is cleared, go to DONE.
  - Each step clears its bit unconditionally; a bit that is already 0 stays 0.
- i_hold:
  - Pauses cnt only; no o_rst bit changes while it is high.
  - Ignored in DONE.
- DONE:
  - o_busy = 0.
  - If i_soft_rst_req == 1 and i_soft_mask != 0: latch the mask, set o_rst |= mask on the next edge, cnt = 0, go to SASSERT.
  - If the request arrives with mask == 0: pulse o_soft_rst_ack on the next cycle and stay in DONE.
- SASSERT:
  - Holds for STEP_DELAY cycles; i_hold is ignored here.
  - Then go to SEQ with idx = 0. Every index is stepped, so timing is deterministic regardless of mask.
- Soft-sequence completion: on entering DONE from a soft-initiated sequence, pulse o_soft_rst_ack for exactly 1 cycle. No ack is issued after a power-on sequence.
- Request outside DONE: not latched. A level still held when DONE is reached is serviced then. The requester must drop req after the ack, otherwise a new sequence starts.
- i_rst mid-sequence, in any state: immediate return to reset values. Any pending ack is lost.
- o_rst is driven straight from flops, with no combinational path to outputs.

Optional Feature:
- Macro: RESET_SEQ_WDT_EN.
- When defined:
  - A watchdog counter runs only in DONE and clears on i_wdt_kick or when leaving DONE.
  - On reaching WDT_CYCLES-1 without a kick: start a soft reset with an all-ones mask. It behaves identically to a soft request, except that no ack is issued.
  - o_wdt_fired is set and stays high until i_rst.
  - A watchdog expiry in the same cycle as a soft request takes priority, and no ack is issued for that request.
- When undefined: the counter, i_wdt_kick and o_wdt_fired are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ppcpu_rst_pkg holds:
  - state enum (HOLD, SEQ, SASSERT, DONE) as 2-bit localparams;
  - domain index constants (RST_DOM_BUS = 0, RST_DOM_MEM = 1, RST_DOM_PERIPH = 2, RST_DOM_CORE = 3).
- One natural sub-module: reset_seq_wdt, the watchdog counter with kick/clear/expire. It is instantiated only under RESET_SEQ_WDT_EN.

Test Plan:
- Power-on: i_rst high 5 cycles, then low, N=4, STEP=16 -> o_rst releases 4'b1111→1110@16→1100@32→1000@48→0000@64; o_busy falls @64; no ack.
- Hold: i_hold high for 10 cycles starting at edge 20 -> o_rst[1] falls @42 instead of @32; later releases shift by 10.
- Soft reset: in DONE, req with mask 4'b1000 -> o_rst = 1000 on the next edge, held 16 cycles, o_rst[3] clears 64 cycles after SASSERT ends; ack is a single pulse; o_rst[2:0] stay 0 throughout.
- Edge requests: req with mask 0 -> ack the next cycle, o_rst unchanged. Req held high during power-on sequence -> serviced on the first DONE cycle.
- Reset mid-soft-sequence: i_rst pulse during SASSERT -> o_rst = 1111 asynchronously, full power-on timing restarts, no ack.
- WDT (RESET_SEQ_WDT_EN, WDT_CYCLES = 100): no kick for 100 DONE cycles -> o_rst = 1111, o_wdt_fired = 1 sticky, no ack. Kick every 50 cycles -> never fires.
